// File: rtl/ddr5_dimm_responder.sv
// DIMM-side responder for one DDR5 channel: decodes split commands, tracks 32 banks,
// flags protocol/timing errors and returns read/write completions after CL/CWL.
module ddr5_dimm_responder #(
  parameter int CHANNEL_ID = 0,
  parameter int TRCD       = 39,
  parameter int TRP        = 39,
  parameter int TRAS       = 76,
  parameter int TCL        = 40,
  parameter int TCWL       = 38
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_type,
  input  logic        cmd_channel,
  input  logic [2:0]  cmd_bg,
  input  logic [1:0]  cmd_bank,
  input  logic [15:0] cmd_row,
  input  logic [5:0]  cmd_col,
  output logic        rd_valid,
  output logic [26:0] rd_tag,
  output logic        wr_ack,
  output logic [26:0] wr_tag,
  output logic        err_valid,
  output logic [2:0]  err_code,
  output logic [5:0]  open_banks
);

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT0 = 3'd1;
  localparam logic [2:0] CMD_ACT1 = 3'd2;
  localparam logic [2:0] CMD_RD0  = 3'd3;
  localparam logic [2:0] CMD_RD1  = 3'd4;
  localparam logic [2:0] CMD_WR0  = 3'd5;
  localparam logic [2:0] CMD_WR1  = 3'd6;
  localparam logic [2:0] CMD_PRE  = 3'd7;

  localparam logic [6:0] TRCD_LD = 7'(TRCD - 1);
  localparam logic [6:0] TRP_LD  = 7'(TRP - 1);
  localparam logic [6:0] TRAS_LD = 7'(TRAS - 1);

  typedef enum logic [0:0] {WAIT_FIRST, WAIT_SECOND} dec_state_e;
  typedef enum logic [1:0] {B_CLOSED, B_ACTIVATING, B_OPEN, B_PRECHARGING} bank_state_e;

  dec_state_e  dec_q, dec_d;
  logic [2:0]  pend_type_q, pend_type_d;
  logic [2:0]  pend_bg_q, pend_bg_d;
  logic [1:0]  pend_bank_q, pend_bank_d;
  logic [15:0] pend_row_q, pend_row_d;
  logic [5:0]  pend_col_q, pend_col_d;

  bank_state_e bank_state_q [32];
  logic [6:0]  bank_cnt_q   [32];
  logic [6:0]  bank_ras_q   [32];
  logic [15:0] bank_row_q   [32];

  logic        err_valid_q, err_now;
  logic [2:0]  err_code_q, err_code_now;
  logic [5:0]  open_cnt_q, open_cnt_d;

  logic [TCL-1:0]  rd_vpipe_q;
  logic [26:0]     rd_tpipe_q [TCL];
  logic [TCWL-1:0] wr_vpipe_q;
  logic [26:0]     wr_tpipe_q [TCWL];

  // Foreign-channel traffic is indistinguishable from an idle cycle.
  logic [2:0] cmd_eff;
  assign cmd_eff = (cmd_valid && (cmd_channel == 1'(CHANNEL_ID))) ? cmd_type : CMD_NOP;

  logic pair_ok;
  assign pair_ok = (cmd_eff == pend_type_q + 3'd1) && (cmd_bg == pend_bg_q) &&
                   (cmd_bank == pend_bank_q) &&
                   ((pend_type_q == CMD_ACT0) ? (cmd_row == pend_row_q) : (cmd_col == pend_col_q));

  logic do_act, do_rd, do_wr, do_pre, split_err;

  always_comb begin
    dec_d       = dec_q;
    pend_type_d = pend_type_q;
    pend_bg_d   = pend_bg_q;
    pend_bank_d = pend_bank_q;
    pend_row_d  = pend_row_q;
    pend_col_d  = pend_col_q;
    do_act      = 1'b0;
    do_rd       = 1'b0;
    do_wr       = 1'b0;
    do_pre      = 1'b0;
    split_err   = 1'b0;
    case (dec_q)
      WAIT_FIRST: begin
        case (cmd_eff)
          CMD_ACT0, CMD_RD0, CMD_WR0: begin
            dec_d       = WAIT_SECOND;
            pend_type_d = cmd_eff;
            pend_bg_d   = cmd_bg;
            pend_bank_d = cmd_bank;
            pend_row_d  = cmd_row;
            pend_col_d  = cmd_col;
          end
          CMD_ACT1, CMD_RD1, CMD_WR1: split_err = 1'b1;
          CMD_PRE:                    do_pre    = 1'b1;
          default: ;
        endcase
      end
      WAIT_SECOND: begin
        dec_d = WAIT_FIRST;
        if (pair_ok) begin
          do_act = (pend_type_q == CMD_ACT0);
          do_rd  = (pend_type_q == CMD_RD0);
          do_wr  = (pend_type_q == CMD_WR0);
        end else begin
          split_err = 1'b1;
        end
      end
      default: dec_d = WAIT_FIRST;
    endcase
  end

  // On a matched pair the live fields equal the latched ones, so the bus addresses the bank.
  logic [4:0]  idx;
  bank_state_e cur_state;
  logic        bank_live, ras_done, act_ok, rd_ok, wr_ok, pre_ok;
  assign idx       = {cmd_bg, cmd_bank};
  assign cur_state = bank_state_q[idx];
  assign bank_live = (cur_state == B_ACTIVATING) || (cur_state == B_OPEN);
  assign ras_done  = (bank_ras_q[idx] == 7'd0);
  assign act_ok    = do_act && (cur_state == B_CLOSED);
  assign rd_ok     = do_rd && (cur_state == B_OPEN);
  assign wr_ok     = do_wr && (cur_state == B_OPEN);
  assign pre_ok    = do_pre && bank_live && ras_done;

  always_comb begin
    err_now      = 1'b1;
    err_code_now = 3'd0;
    if (split_err)                                   err_code_now = 3'd4;
    else if (do_act && bank_live)                    err_code_now = 3'd1;
    else if (do_act && cur_state == B_PRECHARGING)   err_code_now = 3'd5;
    else if ((do_rd || do_wr) && cur_state != B_OPEN) err_code_now = 3'd2;
    else if (do_pre && bank_live && !ras_done)       err_code_now = 3'd3;
    else                                             err_now      = 1'b0;
  end

  always_comb begin
    open_cnt_d = '0;
    for (int i = 0; i < 32; i++) begin
      if (bank_state_q[i] == B_ACTIVATING || bank_state_q[i] == B_OPEN)
        open_cnt_d = open_cnt_d + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q       <= WAIT_FIRST;
      pend_type_q <= CMD_NOP;
      pend_bg_q   <= '0;
      pend_bank_q <= '0;
      pend_row_q  <= '0;
      pend_col_q  <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      open_cnt_q  <= '0;
    end else begin
      dec_q       <= dec_d;
      pend_type_q <= pend_type_d;
      pend_bg_q   <= pend_bg_d;
      pend_bank_q <= pend_bank_d;
      pend_row_q  <= pend_row_d;
      pend_col_q  <= pend_col_d;
      err_valid_q <= err_now;
      if (err_now) err_code_q <= err_code_now;
      open_cnt_q  <= open_cnt_d;
    end
  end

  // Timers free-run first; a legal command to the addressed bank then overrides them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        bank_state_q[i] <= B_CLOSED;
        bank_cnt_q[i]   <= '0;
        bank_ras_q[i]   <= '0;
        bank_row_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (bank_ras_q[i] != 7'd0) bank_ras_q[i] <= bank_ras_q[i] - 7'd1;
        case (bank_state_q[i])
          B_ACTIVATING:
            if (bank_cnt_q[i] == 7'd0) bank_state_q[i] <= B_OPEN;
            else                       bank_cnt_q[i]   <= bank_cnt_q[i] - 7'd1;
          B_PRECHARGING:
            if (bank_cnt_q[i] == 7'd0) bank_state_q[i] <= B_CLOSED;
            else                       bank_cnt_q[i]   <= bank_cnt_q[i] - 7'd1;
          default: ;
        endcase
        if (5'(i) == idx) begin
          if (act_ok) begin
            bank_state_q[i] <= B_ACTIVATING;
            bank_cnt_q[i]   <= TRCD_LD;
            bank_ras_q[i]   <= TRAS_LD;
            bank_row_q[i]   <= cmd_row;
          end
          if (pre_ok) begin
            bank_state_q[i] <= B_PRECHARGING;
            bank_cnt_q[i]   <= TRP_LD;
          end
        end
      end
    end
  end

  logic [26:0] op_tag;
  assign op_tag = {cmd_bg, cmd_bank, bank_row_q[idx], cmd_col};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vpipe_q <= '0;
      wr_vpipe_q <= '0;
      for (int i = 0; i < TCL; i++)  rd_tpipe_q[i] <= '0;
      for (int i = 0; i < TCWL; i++) wr_tpipe_q[i] <= '0;
    end else begin
      rd_vpipe_q    <= {rd_vpipe_q[TCL-2:0], rd_ok};
      rd_tpipe_q[0] <= rd_ok ? op_tag : '0;
      for (int i = 1; i < TCL; i++) rd_tpipe_q[i] <= rd_tpipe_q[i-1];
      wr_vpipe_q    <= {wr_vpipe_q[TCWL-2:0], wr_ok};
      wr_tpipe_q[0] <= wr_ok ? op_tag : '0;
      for (int i = 1; i < TCWL; i++) wr_tpipe_q[i] <= wr_tpipe_q[i-1];
    end
  end

  assign rd_valid   = rd_vpipe_q[TCL-1];
  assign rd_tag     = rd_tpipe_q[TCL-1];
  assign wr_ack     = wr_vpipe_q[TCWL-1];
  assign wr_tag     = wr_tpipe_q[TCWL-1];
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign open_banks = open_cnt_q;

endmodule

// File: tb/tb_ddr5_dimm_responder.sv
// Directed bench for ddr5_dimm_responder: one task per scenario, expected values hand-derived.
module tb_ddr5_dimm_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_type = '0;
  logic        cmd_channel = 1'b0;
  logic [2:0]  cmd_bg = '0;
  logic [1:0]  cmd_bank = '0;
  logic [15:0] cmd_row = '0;
  logic [5:0]  cmd_col = '0;
  logic        rd_valid, wr_ack, err_valid;
  logic [26:0] rd_tag, wr_tag;
  logic [2:0]  err_code;
  logic [5:0]  open_banks;

  ddr5_dimm_responder dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_channel(cmd_channel), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .rd_valid(rd_valid), .rd_tag(rd_tag),
    .wr_ack(wr_ack), .wr_tag(wr_tag), .err_valid(err_valid), .err_code(err_code),
    .open_banks(open_banks)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_type = 3'd0;
    repeat (3) tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  // ---------------- observed pulses (scoreboard side) ----------------
  int          rd_cyc_q[$];
  logic [26:0] rd_tag_q[$];
  int          wr_cyc_q[$];
  logic [26:0] wr_tag_q[$];
  int          err_cyc_q[$];
  logic [2:0]  err_code_q[$];
  logic [26:0] exp_q[$];

  always @(negedge clk) begin
    if (rd_valid)  begin rd_cyc_q.push_back(cyc);  rd_tag_q.push_back(rd_tag); end
    if (wr_ack)    begin wr_cyc_q.push_back(cyc);  wr_tag_q.push_back(wr_tag); end
    if (err_valid) begin err_cyc_q.push_back(cyc); err_code_q.push_back(err_code); end
  end

  task automatic clear_q();
    rd_cyc_q.delete();  rd_tag_q.delete();
    wr_cyc_q.delete();  wr_tag_q.delete();
    err_cyc_q.delete(); err_code_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue_ch(input logic [2:0] t, input logic ch, input logic [2:0] bg,
                          input logic [1:0] bk, input logic [15:0] row, input logic [5:0] col);
    cmd_valid = 1'b1; cmd_type = t; cmd_channel = ch;
    cmd_bg = bg; cmd_bank = bk; cmd_row = row; cmd_col = col;
    tick();
    cmd_valid = 1'b0; cmd_type = 3'd0; cmd_channel = 1'b0;
  endtask

  task automatic issue(input logic [2:0] t, input logic [2:0] bg, input logic [1:0] bk,
                       input logic [15:0] row, input logic [5:0] col);
    issue_ch(t, 1'b0, bg, bk, row, col);
  endtask

  task automatic act(input logic [2:0] bg, input logic [1:0] bk, input logic [15:0] row);
    issue(3'd1, bg, bk, row, 6'd0);
    issue(3'd2, bg, bk, row, 6'd0);
  endtask

  task automatic rd(input logic [2:0] bg, input logic [1:0] bk, input logic [5:0] col);
    issue(3'd3, bg, bk, 16'd0, col);
    issue(3'd4, bg, bk, 16'd0, col);
  endtask

  task automatic wr(input logic [2:0] bg, input logic [1:0] bk, input logic [5:0] col);
    issue(3'd5, bg, bk, 16'd0, col);
    issue(3'd6, bg, bk, 16'd0, col);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({rd_valid, wr_ack, err_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 000", {rd_valid, wr_ack, err_valid});
    end
    n_checks++;
    if ({rd_tag, wr_tag} !== 54'd0) begin
      n_fail++; $display("FAIL reset_tags: got %h/%h want 0/0", rd_tag, wr_tag);
    end
    n_checks++;
    if ({err_code, open_banks} !== 9'd0) begin
      n_fail++; $display("FAIL reset_err_open: got %0d/%0d want 0/0", err_code, open_banks);
    end
  endtask

  task automatic test_read();
    do_reset(); clear_q();
    run_to(10); act(3'd2, 2'd1, 16'h1A2B);
    run_to(13);
    n_checks++;
    if (open_banks !== 6'd1) begin
      n_fail++; $display("FAIL read_open_banks: got %0d want 1", open_banks);
    end
    run_to(50); rd(3'd2, 2'd1, 6'd5);
    run_to(100);
    n_checks++;
    if (rd_cyc_q.size() != 1 || rd_cyc_q[0] != 91) begin
      n_fail++; $display("FAIL read_latency: got %0d pulses first@%0d want 1 @91",
                         rd_cyc_q.size(), rd_cyc_q.size() > 0 ? rd_cyc_q[0] : -1);
    end
    n_checks++;
    if (rd_tag_q.size() != 1 || rd_tag_q[0] !== {3'd2, 2'd1, 16'h1A2B, 6'd5}) begin
      n_fail++; $display("FAIL read_tag: got %h want %h",
                         rd_tag_q.size() > 0 ? rd_tag_q[0] : 27'd0, {3'd2, 2'd1, 16'h1A2B, 6'd5});
    end
    n_checks++;
    if (err_cyc_q.size() != 0 || wr_cyc_q.size() != 0) begin
      n_fail++; $display("FAIL read_no_err: got %0d errs %0d acks want 0 0",
                         err_cyc_q.size(), wr_cyc_q.size());
    end
  endtask

  task automatic test_rd_before_trcd();
    do_reset(); clear_q();
    run_to(10); act(3'd2, 2'd1, 16'h1A2B);
    run_to(29); rd(3'd2, 2'd1, 6'd5);
    run_to(120);
    n_checks++;
    if (err_cyc_q.size() != 1 || err_cyc_q[0] != 31 || err_code_q[0] !== 3'd2) begin
      n_fail++; $display("FAIL trcd_err: got %0d errs first@%0d code %0d want 1 @31 code 2",
                         err_cyc_q.size(), err_cyc_q.size() > 0 ? err_cyc_q[0] : -1,
                         err_code_q.size() > 0 ? err_code_q[0] : 3'd0);
    end
    n_checks++;
    if (err_code !== 3'd2) begin
      n_fail++; $display("FAIL trcd_code_held: got %0d want 2", err_code);
    end
    n_checks++;
    if (rd_cyc_q.size() != 0) begin
      n_fail++; $display("FAIL trcd_no_read: got %0d pulses want 0", rd_cyc_q.size());
    end
  endtask

  task automatic test_pre_timing();
    do_reset(); clear_q();
    run_to(10); act(3'd4, 2'd3, 16'h0042);
    run_to(60); issue(3'd7, 3'd4, 2'd3, 16'd0, 6'd0);
    run_to(62);
    n_checks++;
    if (open_banks !== 6'd1) begin
      n_fail++; $display("FAIL tras_bank_stays_open: got %0d want 1", open_banks);
    end
    run_to(90); issue(3'd7, 3'd4, 2'd3, 16'd0, 6'd0);
    run_to(92);
    n_checks++;
    if (open_banks !== 6'd0) begin
      n_fail++; $display("FAIL pre_accepted: got open_banks %0d want 0", open_banks);
    end
    run_to(99); act(3'd4, 2'd3, 16'h0042);
    run_to(129); act(3'd4, 2'd3, 16'h0042);
    run_to(132);
    n_checks++;
    if (open_banks !== 6'd1) begin
      n_fail++; $display("FAIL act_after_trp: got open_banks %0d want 1", open_banks);
    end
    n_checks++;
    if (err_cyc_q.size() != 2 || err_cyc_q[0] != 61 || err_code_q[0] !== 3'd3 ||
        err_cyc_q[1] != 101 || err_code_q[1] !== 3'd5) begin
      n_fail++; $display("FAIL pre_act_errs: got %0d errs (%0d:%0d) want 2 (61:3, 101:5)",
                         err_cyc_q.size(), err_cyc_q.size() > 0 ? err_cyc_q[0] : -1,
                         err_code_q.size() > 0 ? err_code_q[0] : 3'd0);
    end
  endtask

  task automatic test_split_err();
    do_reset(); clear_q();
    run_to(10);
    issue(3'd1, 3'd0, 2'd0, 16'h1111, 6'd0);
    issue(3'd2, 3'd1, 2'd0, 16'h1111, 6'd0);
    run_to(14);
    n_checks++;
    if (open_banks !== 6'd0) begin
      n_fail++; $display("FAIL split_bank_closed: got open_banks %0d want 0", open_banks);
    end
    run_to(20); issue(3'd4, 3'd0, 2'd0, 16'd0, 6'd1);
    run_to(30); issue(3'd1, 3'd0, 2'd0, 16'h2222, 6'd0);
    run_to(40); rd(3'd0, 2'd0, 6'd1);
    run_to(50);
    issue_ch(3'd1, 1'b1, 3'd5, 2'd2, 16'h3333, 6'd0);
    issue_ch(3'd2, 1'b1, 3'd5, 2'd2, 16'h3333, 6'd0);
    run_to(54);
    n_checks++;
    if (open_banks !== 6'd0) begin
      n_fail++; $display("FAIL other_channel_ignored: got open_banks %0d want 0", open_banks);
    end
    n_checks++;
    if (err_cyc_q.size() != 4 || err_cyc_q[0] != 12 || err_code_q[0] !== 3'd4 ||
        err_cyc_q[1] != 21 || err_code_q[1] !== 3'd4 ||
        err_cyc_q[2] != 32 || err_code_q[2] !== 3'd4 ||
        err_cyc_q[3] != 42 || err_code_q[3] !== 3'd2) begin
      n_fail++; $display("FAIL split_errs: got %0d errs want 4 (12:4 21:4 32:4 42:2)",
                         err_cyc_q.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); clear_q();
    run_to(10); act(3'd3, 2'd2, 16'h00FF);
    act(3'd7, 2'd3, 16'hBEEF);
    run_to(20);
    n_checks++;
    if (open_banks !== 6'd2) begin
      n_fail++; $display("FAIL b2b_open_banks: got %0d want 2", open_banks);
    end
    exp_q.push_back({3'd3, 2'd2, 16'h00FF, 6'd9});
    exp_q.push_back({3'd3, 2'd2, 16'h00FF, 6'd10});
    exp_q.push_back({3'd3, 2'd2, 16'h00FF, 6'd11});
    run_to(197); rd(3'd3, 2'd2, 6'd9);
    wr(3'd7, 2'd3, 6'h3F);
    rd(3'd3, 2'd2, 6'd10);
    rd(3'd3, 2'd2, 6'd11);
    run_to(260);
    n_checks++;
    if (wr_cyc_q.size() != 1 || wr_cyc_q[0] != 238 || wr_tag_q[0] !== {3'd7, 2'd3, 16'hBEEF, 6'h3F}) begin
      n_fail++; $display("FAIL b2b_write: got %0d acks first@%0d tag %h want 1 @238 tag %h",
                         wr_cyc_q.size(), wr_cyc_q.size() > 0 ? wr_cyc_q[0] : -1,
                         wr_tag_q.size() > 0 ? wr_tag_q[0] : 27'd0, {3'd7, 2'd3, 16'hBEEF, 6'h3F});
    end
    n_checks++;
    if (rd_cyc_q.size() != 3 || rd_cyc_q[0] != 238 || rd_cyc_q[1] != 242 || rd_cyc_q[2] != 244) begin
      n_fail++; $display("FAIL b2b_read_cycles: got %0d reads first@%0d want 3 @238/242/244",
                         rd_cyc_q.size(), rd_cyc_q.size() > 0 ? rd_cyc_q[0] : -1);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= rd_tag_q.size() || rd_tag_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_read_tag[%0d]: got %h want %h", i,
                           i < rd_tag_q.size() ? rd_tag_q[i] : 27'd0, exp_q[i]);
      end
    end
    n_checks++;
    if (err_cyc_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_no_err: got %0d errs want 0", err_cyc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); clear_q();
    run_to(10); act(3'd2, 2'd1, 16'h1A2B);
    run_to(20); issue(3'd4, 3'd2, 2'd1, 16'd0, 6'd0);
    run_to(50); rd(3'd2, 2'd1, 6'd5);
    run_to(61);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rd_valid, wr_ack, err_valid, err_code, open_banks} !== 12'd0) begin
      n_fail++; $display("FAIL midreset_immediate: got err_code %0d open %0d want 0 0",
                         err_code, open_banks);
    end
    repeat (3) tick();
    rst = 1'b0;
    run_to(130);
    n_checks++;
    if (rd_cyc_q.size() != 0) begin
      n_fail++; $display("FAIL midreset_flush: got %0d read pulses want 0", rd_cyc_q.size());
    end
    n_checks++;
    if (open_banks !== 6'd0 || err_code !== 3'd0) begin
      n_fail++; $display("FAIL midreset_state: got open %0d err_code %0d want 0 0",
                         open_banks, err_code);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_read();
    test_rd_before_trcd();
    test_pre_timing();
    test_split_err();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
